// File: rtl/instr_decode_queue_if.sv
// Handshake and decoded-field bundle for instr_decode_queue.
// master drives instructions in and accepts decoded entries out.
interface instr_decode_queue_if #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     Instr;
  logic [PC_W-1:0] pc_in;
  logic            out_valid;
  logic            out_ready;
  logic [6:0]      Op_Code;
  logic [9:0]      funct;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [4:0]      shamt;
  logic [31:0]     Imm;
  logic [PC_W-1:0] pc_out;
  logic            illegal;
  logic [CW-1:0]   count;

  modport master (
    output in_valid, Instr, pc_in, out_ready,
    input  in_ready, out_valid, Op_Code, funct,
    input  rs1, rs2, rd, shamt, Imm, pc_out,
    input  illegal, count
  );

  modport slave (
    input  in_valid, Instr, pc_in, out_ready,
    output in_ready, out_valid, Op_Code, funct,
    output rs1, rs2, rd, shamt, Imm, pc_out,
    output illegal, count
  );
endinterface

// File: rtl/instr_decode_queue.sv
// RV32I decode-at-push FIFO; head entry presented on the out side.
// Optional macro DECQ_BYPASS_EN: empty-queue 0-cycle pass-through.
module instr_decode_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input logic clk,
  input logic rst,
  input logic flush,
  instr_decode_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [6:0]      op;
    logic [9:0]      funct;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [4:0]      shamt;
    logic [31:0]     imm;
    logic [PC_W-1:0] pc;
    logic            ill;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  entry_t dec;
  entry_t sel;
  logic   byp;
  logic   push;
  logic   pop;
  logic   full;
  logic   empty;

  logic [31:0] ins;
  logic is_r, is_i, is_s, is_b, is_u, is_j;

  assign ins   = q.Instr;
  assign is_r  = ins[6:0] == 7'b0110011;
  assign is_i  = ins[6:0] == 7'b0000011 ||
                 ins[6:0] == 7'b0010011 ||
                 ins[6:0] == 7'b1100111;
  assign is_s  = ins[6:0] == 7'b0100011;
  assign is_b  = ins[6:0] == 7'b1100011;
  assign is_u  = ins[6:0] == 7'b0110111 ||
                 ins[6:0] == 7'b0010111;
  assign is_j  = ins[6:0] == 7'b1101111;

  // Decode the incoming instruction into a queue entry.
  always_comb begin
    dec       = '0;
    dec.op    = ins[6:0];
    dec.funct = {ins[31:25], ins[14:12]};
    dec.rs1   = ins[19:15];
    dec.rs2   = ins[24:20];
    dec.shamt = ins[24:20];
    dec.rd    = (is_s || is_b) ? 5'd0 : ins[11:7];
    dec.pc    = q.pc_in;
    unique case (1'b1)
      is_i: dec.imm = {{20{ins[31]}}, ins[31:20]};
      is_s: dec.imm = {{20{ins[31]}}, ins[31:25],
                       ins[11:7]};
      is_b: dec.imm = {{19{ins[31]}}, ins[31], ins[7],
                       ins[30:25], ins[11:8], 1'b0};
      is_u: dec.imm = {ins[31:12], 12'b0};
      is_j: dec.imm = {{11{ins[31]}}, ins[31],
                       ins[19:12], ins[20],
                       ins[30:21], 1'b0};
      is_r: dec.imm = '0;
      default: dec.ill = 1'b1;
    endcase
  end

  assign empty = count_q == '0;
  assign full  = count_q == CW'(DEPTH);

`ifdef DECQ_BYPASS_EN
  assign byp = empty && q.in_valid && q.out_ready &&
               !flush && !rst;
`else
  assign byp = 1'b0;
`endif

  assign push = q.in_valid && !full && !flush && !byp;
  assign pop  = !empty && q.out_ready && !flush;

  // Next-state pointers, occupancy and storage write.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (push) begin
      mem_d[tail_q] = dec;
      tail_d        = tail_q + 1'b1;
    end
    if (pop) head_d = head_q + 1'b1;
    if (push && !pop) count_d = count_q + 1'b1;
    if (pop && !push) count_d = count_q - 1'b1;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Register pointers, count and entries; reset clears all.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  // Pick the presented entry: bypassed input or queue head.
  always_comb begin
    sel = '0;
    if (rst)         sel = '0;
    else if (byp)    sel = dec;
    else if (!empty) sel = mem_q[head_q];
  end

  assign q.in_ready  = !full;
  assign q.out_valid = !rst && (byp || !empty);
  assign q.Op_Code   = sel.op;
  assign q.funct     = sel.funct;
  assign q.rs1       = sel.rs1;
  assign q.rs2       = sel.rs2;
  assign q.rd        = sel.rd;
  assign q.shamt     = sel.shamt;
  assign q.Imm       = sel.imm;
  assign q.pc_out    = sel.pc;
  assign q.illegal   = sel.ill;
  assign q.count     = count_q;
endmodule

// File: tb/tb_instr_decode_queue.sv
// Directed bench for instr_decode_queue (DEPTH=4, PC_W=32).
// Vector table for decode plus sequences for fill/flush/reset.
module tb_instr_decode_queue;
  logic clk = 1'b0;
  logic rst;
  logic flush;

  instr_decode_queue_if #(.DEPTH(4), .PC_W(32)) bus();

  instr_decode_queue #(.DEPTH(4), .PC_W(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .q     (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] instr;
    logic [6:0]  op;
    logic [9:0]  funct;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_hold(input logic [31:0] ins,
                           input logic [31:0] pc);
    bus.Instr    = ins;
    bus.pc_in    = pc;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    vt[0]  = '{32'h00500093, 7'h13, 10'h000, 5'd0,
               5'd5, 5'd1, 5'd5, 32'h00000005, 1'b0};
    vt[1]  = '{32'hFE21AE23, 7'h23, 10'h3FA, 5'd3,
               5'd2, 5'd0, 5'd2, 32'hFFFFFFFC, 1'b0};
    vt[2]  = '{32'h008000EF, 7'h6F, 10'h000, 5'd0,
               5'd8, 5'd1, 5'd8, 32'h00000008, 1'b0};
    vt[3]  = '{32'h0000007F, 7'h7F, 10'h000, 5'd0,
               5'd0, 5'd0, 5'd0, 32'h00000000, 1'b1};
    vt[4]  = '{32'h00000000, 7'h00, 10'h000, 5'd0,
               5'd0, 5'd0, 5'd0, 32'h00000000, 1'b1};
    vt[5]  = '{32'h123450B7, 7'h37, 10'h04D, 5'd8,
               5'd3, 5'd1, 5'd3, 32'h12345000, 1'b0};
    vt[6]  = '{32'hFE000EE3, 7'h63, 10'h3F8, 5'd0,
               5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b0};
    vt[7]  = '{32'hFFF12283, 7'h03, 10'h3FA, 5'd2,
               5'd31, 5'd5, 5'd31, 32'hFFFFFFFF, 1'b0};
    vt[8]  = '{32'h402081B3, 7'h33, 10'h100, 5'd1,
               5'd2, 5'd3, 5'd2, 32'h00000000, 1'b0};
    vt[9]  = '{32'hFF8080E7, 7'h67, 10'h3F8, 5'd1,
               5'd24, 5'd1, 5'd24, 32'hFFFFFFF8, 1'b0};
    vt[10] = '{32'hFFFFF017, 7'h17, 10'h3FF, 5'd31,
               5'd31, 5'd0, 5'd31, 32'hFFFFF000, 1'b0};

    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.Instr     = '0;
    bus.pc_in     = '0;

    step();
    step();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_op", 64'(bus.Op_Code), 64'd0);
    chk("rst_imm", 64'(bus.Imm), 64'd0);
    chk("rst_pc", 64'(bus.pc_out), 64'd0);
    rst = 1'b0;
    step();
    chk("post_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("post_rst_rd", 64'(bus.rd), 64'd0);

    bus.Instr     = 32'h00500093;
    bus.pc_in     = 32'h80;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
`ifdef DECQ_BYPASS_EN
    chk("byp_valid", 64'(bus.out_valid), 64'd1);
    chk("byp_imm", 64'(bus.Imm), 64'd5);
    chk("byp_count", 64'(bus.count), 64'd0);
    step();
    bus.in_valid = 1'b0;
    chk("byp_count_after", 64'(bus.count), 64'd0);
`else
    chk("lat_valid_pre", 64'(bus.out_valid), 64'd0);
    step();
    bus.in_valid = 1'b0;
    chk("lat_valid", 64'(bus.out_valid), 64'd1);
    chk("lat_op", 64'(bus.Op_Code), 64'h13);
    chk("lat_rd", 64'(bus.rd), 64'd1);
    chk("lat_rs1", 64'(bus.rs1), 64'd0);
    chk("lat_imm", 64'(bus.Imm), 64'd5);
    chk("lat_funct", 64'(bus.funct), 64'd0);
    chk("lat_ill", 64'(bus.illegal), 64'd0);
    chk("lat_pc", 64'(bus.pc_out), 64'h80);
    step();
    chk("lat_drain", 64'(bus.count), 64'd0);
`endif
    bus.out_ready = 1'b0;

    for (int i = 0; i < 11; i++) begin
      push_hold(vt[i].instr, 32'h1000 + 32'(i * 4));
      chk("vec_valid", 64'(bus.out_valid), 64'd1);
      chk("vec_op", 64'(bus.Op_Code), 64'(vt[i].op));
      chk("vec_funct", 64'(bus.funct), 64'(vt[i].funct));
      chk("vec_rs1", 64'(bus.rs1), 64'(vt[i].rs1));
      chk("vec_rs2", 64'(bus.rs2), 64'(vt[i].rs2));
      chk("vec_rd", 64'(bus.rd), 64'(vt[i].rd));
      chk("vec_shamt", 64'(bus.shamt), 64'(vt[i].shamt));
      chk("vec_imm", 64'(bus.Imm), 64'(vt[i].imm));
      chk("vec_ill", 64'(bus.illegal), 64'(vt[i].ill));
      chk("vec_pc", 64'(bus.pc_out),
          64'(32'h1000 + 32'(i * 4)));
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      chk("vec_empty", 64'(bus.count), 64'd0);
    end

    bus.in_valid = 1'b0;
    bus.Instr    = 32'h00100093;
    bus.in_valid = 1'b1;
    step();
    bus.Instr    = 32'hFE21AE23;
    step();
    bus.Instr    = 32'h008000EF;
    step();
    bus.in_valid = 1'b0;
    chk("pair_count", 64'(bus.count), 64'd3);
    bus.out_ready = 1'b1;
    step();
    chk("pair1_imm", 64'(bus.Imm), 64'hFFFFFFFC);
    chk("pair1_rd", 64'(bus.rd), 64'd0);
    chk("pair1_rs1", 64'(bus.rs1), 64'd3);
    chk("pair1_rs2", 64'(bus.rs2), 64'd2);
    step();
    chk("pair2_op", 64'(bus.Op_Code), 64'h6F);
    chk("pair2_rd", 64'(bus.rd), 64'd1);
    chk("pair2_imm", 64'(bus.Imm), 64'd8);
    step();
    bus.out_ready = 1'b0;
    chk("pair_empty", 64'(bus.count), 64'd0);

    for (int k = 1; k <= 5; k++) begin
      bus.Instr    = 32'h00000093 | (32'(k) << 20);
      bus.pc_in    = 32'(k);
      bus.in_valid = 1'b1;
      step();
      chk("fill_head_stable", 64'(bus.Imm), 64'd1);
      if (k >= 4) begin
        chk("fill_count", 64'(bus.count), 64'd4);
        chk("fill_in_ready", 64'(bus.in_ready), 64'd0);
      end
    end
    bus.out_ready = 1'b1;
    step();
    chk("full_pop_count", 64'(bus.count), 64'd3);
    chk("full_pop_head", 64'(bus.Imm), 64'd2);
    chk("full_pop_ready", 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
    chk("wrap_count", 64'(bus.count), 64'd3);
    chk("wrap_head", 64'(bus.Imm), 64'd3);
    step();
    chk("wrap_head4", 64'(bus.Imm), 64'd4);
    step();
    chk("wrap_head5", 64'(bus.Imm), 64'd5);
    chk("wrap_pc5", 64'(bus.pc_out), 64'd5);
    chk("wrap_count1", 64'(bus.count), 64'd1);
    step();
    chk("wrap_empty", 64'(bus.count), 64'd0);
    chk("wrap_valid", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b0;

    for (int k = 1; k <= 3; k++)
      push_hold(32'h00000093 | (32'(k) << 20), 32'(k));
    chk("fl_pre_count", 64'(bus.count), 64'd3);
    flush         = 1'b1;
    bus.Instr     = 32'h00900093;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    step();
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("fl_count", 64'(bus.count), 64'd0);
    chk("fl_valid", 64'(bus.out_valid), 64'd0);
    step();
    chk("fl_stays_empty", 64'(bus.count), 64'd0);
    push_hold(32'h00700093, 32'h70);
    chk("fl_new_head", 64'(bus.Imm), 64'd7);
    chk("fl_new_count", 64'(bus.count), 64'd1);

    push_hold(32'h00800093, 32'h74);
    chk("mr_pre_count", 64'(bus.count), 64'd2);
    rst = 1'b1;
    #1;
    chk("mr_valid_in_rst", 64'(bus.out_valid), 64'd0);
    chk("mr_op_in_rst", 64'(bus.Op_Code), 64'd0);
    step();
    rst = 1'b0;
    chk("mr_count", 64'(bus.count), 64'd0);
    step();
    chk("mr_valid_after", 64'(bus.out_valid), 64'd0);
    chk("mr_imm_after", 64'(bus.Imm), 64'd0);
    chk("mr_pc_after", 64'(bus.pc_out), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
